rank_filter_run_ctrl: RTL and testbench
=======================================

Name: rank_filter_run_ctrl

Overview:
Sequencer for the adaptive rank-order filter datapath. It replaces the free-running ROM address counter and gated filter clock with a start/done controlled run: it issues ROM reads, drives the filter clock-enable, inserts end-of-stream padding and writes aligned filter results into the result RAM. When no run is active it owns the result RAM read-back address, which is stepped by the push-buttons.

Parameters:
N, 5, filter window length (odd, >=3)
ADDR_BITS, 8, width of ROM, RAM and read-back addresses
NUM_SAMPLES, 255, samples per run (1..2^ADDR_BITS)
FILT_LAT, N/2+1, filter latency in enabled cycles from input to aligned output

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  level; rising edge in IDLE or DONE begins a run
abort  in  1  level; when high, any run state returns to IDLE next cycle
pause  in  1  level; freezes ROM issue and filter advance while high
rd_up  in  1  debounced button level; rising edge increments rd_addr
rd_down  in  1  debounced button level; rising edge decrements rd_addr
rom_addr  out  ADDR_BITS  ROM read address
rom_en  out  1  ROM read enable; data is valid 1 cycle later
filt_clr  out  1  one-cycle synchronous clear of the filter window
filt_en  out  1  filter clock-enable
filt_pad  out  1  filter input mux selects pad value instead of ROM data
ram_wr_en  out  1  result RAM write strobe
ram_wr_addr  out  ADDR_BITS  result RAM write address
rd_addr  out  ADDR_BITS  result RAM read address for display
busy  out  1  high in CLEAR, RUN and FLUSH
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE. All outputs 0. Counters 0. Edge-detect history registers 0.
- Edge detect: each of start, rd_up and rd_down is registered once. An edge means the current value is 1 and the registered value is 0.
- States: IDLE, CLEAR, RUN, FLUSH, DONE.
- IDLE/DONE + start edge -> CLEAR. In CLEAR, filt_clr=1 for 1 cycle. rom_addr, en_cnt and ram_wr_addr are zeroed. done drops. Next state is RUN.
- RUN: when pause=0, rom_en=1 with rom_addr = issue count, and the issue count increments. When pause=1, rom_en=0 and nothing advances. After NUM_SAMPLES issues the state goes to FLUSH.
- filt_en is rom_en registered by 1 cycle, so it aligns with ROM data. Pausing therefore stalls the filter 1 cycle later. The ROM holds its output while not enabled.
- FLUSH: the first cycle carries the pipelined filt_en of the last ROM sample with filt_pad=0. This is followed by FILT_LAT cycles with filt_en=1 and filt_pad=1. pause stalls FLUSH the same way (filt_en=0 and the count holds).
- en_cnt counts filt_en cycles since CLEAR, saturating at FILT_LAT. ram_wr_en = filt_en AND en_cnt==FILT_LAT, where en_cnt is the value before that cycle's increment.
- ram_wr_addr increments after each write. Exactly NUM_SAMPLES writes occur, with the last at address NUM_SAMPLES-1.
- After the last write the state goes to DONE. busy=0, done=1, held until the next start edge.
- abort in CLEAR/RUN/FLUSH: the state goes to IDLE next cycle. rom_en, filt_en, filt_pad and ram_wr_en are 0 from that cycle. RAM contents are undefined. abort in IDLE/DONE has no effect.
- Start edge while busy is ignored.
- rd_addr changes only in IDLE/DONE. A rd_up edge gives +1 and a rd_down edge gives -1, modulo 2^ADDR_BITS (wraps 255<->0). Simultaneous edges leave rd_addr unchanged. Edges while busy are discarded (not queued). rd_addr is not cleared by start.
- Asynchronous rst mid-run: immediate return to the reset values. No write strobe may appear in the reset cycle.
- Timing with pause=0, start edge sampled at cycle 0:
  - CLEAR at cycle 1.
  - rom_en cycles 2..NUM_SAMPLES+1.
  - First ram_wr_en at cycle 3+FILT_LAT.
  - Last write at cycle 2+NUM_SAMPLES+FILT_LAT.
  - done=1 from cycle 3+NUM_SAMPLES+FILT_LAT.

Test Plan:
- Defaults, start pulse at cycle 0 -> filt_clr at 1; rom_addr 0..254 on cycles 2..256; first write at cycle 6 to addr 0; last write at cycle 260 to addr 254; done=1 at 261; exactly 255 ram_wr_en pulses; filt_pad=1 on cycles 258..260.
- pause high for 4 cycles at cycle 50 -> rom_addr frozen, filt_en low one cycle later, 4-cycle delay added to every later write; write sequence contiguous with no gaps in addresses and no duplicates.
- abort at cycle 100 -> IDLE at 101, all strobes 0, done=0; a following start produces a full clean run beginning at ram_wr_addr 0.
- In DONE, rd_down edge with rd_addr=0 -> 255; rd_up edge -> 0; simultaneous edges -> unchanged; rd_up edge during busy -> ignored.
- rst asserted at cycle 150 mid-run -> all outputs 0 immediately; rd_addr 0; state IDLE.
- NUM_SAMPLES=1, N=3 (FILT_LAT=2) -> single rom_en at cycle 2, single write to addr 0 at cycle 5, done at cycle 6.

Source files
------------

// File: rtl/rank_filter_run_ctrl.sv
// rank_filter_run_ctrl
// Start/done sequencer for the adaptive rank-order filter datapath.
// Issues ROM reads, drives the filter clock-enable and pad select, writes
// aligned filter results into the result RAM and, when idle, steps the
// result RAM read-back address from the push-buttons.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start, abort, pause run control levels
//   rd_up, rd_down      debounced read-back buttons
//   rom_addr, rom_en    ROM read port (data valid one cycle after rom_en)
//   filt_clr, filt_en,  filter window clear, clock-enable and pad select
//   filt_pad
//   ram_wr_en,          result RAM write port
//   ram_wr_addr
//   rd_addr             result RAM read-back address
//   busy, done          run status
//
// state | meaning
// IDLE  | no run active, read-back address follows buttons
// CLEAR | one cycle: clear filter window, zero run counters
// RUN   | issue NUM_SAMPLES ROM reads (stalled by pause)
// FLUSH | feed FILT_LAT pad samples until the last result is written
// DONE  | run complete, read-back address follows buttons
module rank_filter_run_ctrl #(
    parameter int N           = 5,
    parameter int ADDR_BITS   = 8,
    parameter int NUM_SAMPLES = 255,
    parameter int FILT_LAT    = N / 2 + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic                 rd_up,
    input  logic                 rd_down,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 rom_en,
    output logic                 filt_clr,
    output logic                 filt_en,
    output logic                 filt_pad,
    output logic                 ram_wr_en,
    output logic [ADDR_BITS-1:0] ram_wr_addr,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(FILT_LAT + 1);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0]        LAT      = CW'(FILT_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                 start_q, up_q, down_q;
    logic                 start_edge, up_edge, down_edge;
    logic [ADDR_BITS-1:0] issue_cnt;
    logic [CW-1:0]        en_cnt;
    logic [CW-1:0]        pad_left;
    logic                 filt_en_q, filt_pad_q;
    logic                 pad_issue;
    logic                 enter_clear;

    assign start_edge = start & ~start_q;
    assign up_edge    = rd_up & ~up_q;
    assign down_edge  = rd_down & ~down_q;

    assign rom_addr  = issue_cnt;
    assign filt_en   = filt_en_q;
    assign filt_pad  = filt_pad_q;
    // en_cnt is the pre-increment count, so the write lines up with the
    // first filter output that covers a full window.
    assign ram_wr_en = filt_en_q & (en_cnt == LAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rom_en      = 1'b0;
        pad_issue   = 1'b0;
        filt_clr    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        enter_clear = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start_edge) begin
                    state_nxt   = S_CLEAR;
                    enter_clear = 1'b1;
                end
            end
            S_CLEAR: begin
                busy      = 1'b1;
                filt_clr  = 1'b1;
                state_nxt = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                rom_en = ~pause;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!pause && issue_cnt == LAST_IDX) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy      = 1'b1;
                pad_issue = ~pause & (pad_left != '0);
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (ram_wr_en && ram_wr_addr == LAST_IDX) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            issue_cnt   <= '0;
            en_cnt      <= '0;
            pad_left    <= '0;
            filt_en_q   <= 1'b0;
            filt_pad_q  <= 1'b0;
            ram_wr_addr <= '0;
            rd_addr     <= '0;
        end else begin
            start_q <= start;
            up_q    <= rd_up;
            down_q  <= rd_down;

            // Filter enable trails the issue by one cycle so it meets ROM data.
            filt_en_q  <= (rom_en | pad_issue) & ~abort;
            filt_pad_q <= pad_issue & ~abort;

            if (enter_clear) begin
                issue_cnt   <= '0;
                en_cnt      <= '0;
                pad_left    <= LAT;
                ram_wr_addr <= '0;
            end else begin
                if (rom_en) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (pad_issue) begin
                    pad_left <= pad_left - 1'b1;
                end
                if (filt_en_q && en_cnt != LAT) begin
                    en_cnt <= en_cnt + 1'b1;
                end
                if (ram_wr_en) begin
                    ram_wr_addr <= ram_wr_addr + 1'b1;
                end
            end

            // Button edges outside IDLE/DONE are dropped, not queued.
            if (!busy && (up_edge ^ down_edge)) begin
                rd_addr <= up_edge ? rd_addr + 1'b1 : rd_addr - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rank_filter_run_ctrl.sv
// Testbench for rank_filter_run_ctrl: directed run sequence with random
// pause patterns, checked against an event-list model of a run.
module tb_rank_filter_run_ctrl;

    localparam int NS   = 255;
    localparam int FL   = 3;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst;
    logic start, abort, pause, rd_up, rd_down, start_s;

    logic [7:0] rom_addr, ram_wr_addr, rd_addr;
    logic       rom_en, filt_clr, filt_en, filt_pad, ram_wr_en, busy, done;
    logic [7:0] rom_addr_s, ram_wr_addr_s, rd_addr_s;
    logic       rom_en_s, filt_clr_s, filt_en_s, filt_pad_s, ram_wr_en_s, busy_s, done_s;

    always #5 clk = ~clk;

    rank_filter_run_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .rd_up(rd_up), .rd_down(rd_down), .rom_addr(rom_addr), .rom_en(rom_en),
        .filt_clr(filt_clr), .filt_en(filt_en), .filt_pad(filt_pad),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .rd_addr(rd_addr),
        .busy(busy), .done(done)
    );

    rank_filter_run_ctrl #(.N(3), .ADDR_BITS(8), .NUM_SAMPLES(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(1'b0), .pause(1'b0),
        .rd_up(1'b0), .rd_down(1'b0), .rom_addr(rom_addr_s), .rom_en(rom_en_s),
        .filt_clr(filt_clr_s), .filt_en(filt_en_s), .filt_pad(filt_pad_s),
        .ram_wr_en(ram_wr_en_s), .ram_wr_addr(ram_wr_addr_s), .rd_addr(rd_addr_s),
        .busy(busy_s), .done(done_s)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    bit pz[MAXC];
    bit e_ren[MAXC];
    bit e_rvalid[MAXC];
    int e_raddr[MAXC];
    bit e_fen[MAXC];
    bit e_pad[MAXC];
    bit e_wr[MAXC];
    int e_waddr[MAXC];
    int done_c;
    int rd_m;

    task automatic check(input string tag, input int c, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    // Event-list model of one run, cycle 0 = start edge sampled.
    task automatic build_model(input int ns, input int fl);
        int issued, last_issue, pads, k, c;
        for (int i = 0; i < MAXC; i++) begin
            e_ren[i] = 0; e_rvalid[i] = 0; e_raddr[i] = 0; e_fen[i] = 0;
            e_pad[i] = 0; e_wr[i] = 0; e_waddr[i] = 0;
        end
        e_rvalid[1] = 1;
        e_raddr[1]  = 0;
        issued = 0;
        last_issue = 1;
        c = 2;
        while (issued < ns) begin
            e_rvalid[c] = 1;
            e_raddr[c]  = issued;
            if (!pz[c]) begin
                e_ren[c]   = 1;
                e_fen[c+1] = 1;
                issued++;
                last_issue = c;
            end
            c++;
        end
        pads = 0;
        c = last_issue + 1;
        while (pads < fl) begin
            if (!pz[c]) begin
                e_fen[c+1] = 1;
                e_pad[c+1] = 1;
                pads++;
            end
            c++;
        end
        k = 0;
        done_c = 0;
        for (int i = 0; i < MAXC; i++) begin
            if (e_fen[i]) begin
                if (k >= fl) begin
                    e_wr[i]    = 1;
                    e_waddr[i] = k - fl;
                    done_c     = i + 1;
                end
                k++;
            end
        end
    endtask

    task automatic fill_pause(input bit random_on, input int pause_at);
        for (int i = 0; i < MAXC; i++) begin
            pz[i] = (random_on && i >= 2) ? ($urandom_range(0, 9) == 0) : 1'b0;
        end
        if (pause_at >= 0) begin
            for (int i = pause_at; i < pause_at + 4; i++) pz[i] = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag, input int c);
        check({tag, "_rom_en"}, c, rom_en, 0);
        check({tag, "_filt_en"}, c, filt_en, 0);
        check({tag, "_filt_pad"}, c, filt_pad, 0);
        check({tag, "_ram_wr_en"}, c, ram_wr_en, 0);
        check({tag, "_filt_clr"}, c, filt_clr, 0);
        check({tag, "_busy"}, c, busy, 0);
        check({tag, "_done"}, c, done, 0);
    endtask

    task automatic run_main(input int abort_at, input int rst_at, input int busy_press,
                            input bit prev_done);
        int wr_seen;
        wr_seen = 0;
        for (int c = 0; c <= done_c + 2; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (c == 40);
            pause = pz[c];
            abort = (c == abort_at);
            rd_up = (c == busy_press);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("rst", c);
                check("rst_rom_addr", c, rom_addr, 0);
                check("rst_ram_wr_addr", c, ram_wr_addr, 0);
                check("rst_rd_addr", c, rd_addr, 0);
                rd_m = 0;
                @(negedge clk);
                check("rst_ram_wr_en_hold", c, ram_wr_en, 0);
                start = 0; pause = 0; rd_up = 0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            if (abort_at >= 0 && c > abort_at) begin
                check_all_zero("abort", c);
                check("abort_rd_addr", c, rd_addr, rd_m);
                if (c == abort_at + 5) return;
                continue;
            end
            if (c == abort_at) begin
                check("abort_cyc_busy", c, busy, 1);
                continue;
            end
            check("rom_en", c, rom_en, e_ren[c]);
            if (e_rvalid[c]) check("rom_addr", c, rom_addr, e_raddr[c]);
            check("filt_clr", c, filt_clr, c == 1);
            check("filt_en", c, filt_en, e_fen[c]);
            check("filt_pad", c, filt_pad, e_pad[c]);
            check("ram_wr_en", c, ram_wr_en, e_wr[c]);
            if (e_wr[c]) check("ram_wr_addr", c, ram_wr_addr, e_waddr[c]);
            check("busy", c, busy, c >= 1 && c < done_c);
            check("done", c, done, c == 0 ? prev_done : c >= done_c);
            check("rd_addr", c, rd_addr, rd_m);
            if (ram_wr_en) wr_seen++;
        end
        start = 0; pause = 0; abort = 0; rd_up = 0;
        check("wr_count", done_c, wr_seen, NS);
    endtask

    task automatic press(input bit up, input bit dn);
        @(posedge clk);
        #1;
        rd_up = up;
        rd_down = dn;
        @(posedge clk);
        #1;
        rd_up = 0;
        rd_down = 0;
        if (up != dn) rd_m = up ? (rd_m + 1) % 256 : (rd_m + 255) % 256;
        @(negedge clk);
        check("rd_press", 0, rd_addr, rd_m);
        check("rd_press_done", 0, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 0; abort = 0; pause = 0; rd_up = 0; rd_down = 0; start_s = 0;
        rd_m = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset", 0);
        check("reset_rom_addr", 0, rom_addr, 0);
        check("reset_ram_wr_addr", 0, ram_wr_addr, 0);
        check("reset_rd_addr", 0, rd_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: random pauses plus a 4-cycle pause at cycle 50, re-start
        // pulse and rd_up press while busy.
        fill_pause(1'b1, 50);
        build_model(NS, FL);
        run_main(-1, -1, 30, 1'b0);

        // Read-back stepping in DONE.
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (rd_m == 0) press(1'b1, 1'b0);

        // Run 2: abort at cycle 100.
        fill_pause(1'b1, -1);
        build_model(NS, FL);
        run_main(100, -1, -1, 1'b1);

        // Run 3: clean run after abort, no pause.
        fill_pause(1'b0, -1);
        build_model(NS, FL);
        run_main(-1, -1, -1, 1'b0);

        // Run 4: asynchronous reset at cycle 150.
        fill_pause(1'b0, -1);
        build_model(NS, FL);
        run_main(-1, 150, -1, 1'b1);

        // Single-sample instance with N=3.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            start_s = (c == 0);
            @(negedge clk);
            check("s_rom_en", c, rom_en_s, c == 2);
            check("s_filt_clr", c, filt_clr_s, c == 1);
            check("s_filt_en", c, filt_en_s, c >= 3 && c <= 5);
            check("s_filt_pad", c, filt_pad_s, c == 4 || c == 5);
            check("s_ram_wr_en", c, ram_wr_en_s, c == 5);
            if (c == 5) check("s_ram_wr_addr", c, ram_wr_addr_s, 0);
            check("s_busy", c, busy_s, c >= 1 && c <= 5);
            check("s_done", c, done_s, c >= 6);
        end
        start_s = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
